// File: rtl/fifo_wide2narrow_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package   : fifo_wide2narrow_pkg                                        |
// | Purpose   : Shared widths and helpers for the wide-to-narrow FIFO.      |
// |             An entry is 16 words of 16 bits plus a 4-bit size field;    |
// |             size 0 encodes a full 16-word entry.                        |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package fifo_wide2narrow_pkg;

  localparam int WORD_W          = 16;
  localparam int WORDS_PER_ENTRY = 16;
  localparam int ENTRY_W         = WORD_W * WORDS_PER_ENTRY;  // 256
  localparam int SIZE_W          = 4;

  // Index of the last valid word of an entry. Size 0 means all 16 words.
  function automatic logic [SIZE_W-1:0] size_to_last(input logic [SIZE_W-1:0] size);
    if (size == '0) begin
      return '1;
    end else begin
      return size - SIZE_W'(1);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wide2narrow_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : fifo_wide2narrow_mem                                        |
// | Purpose   : DEPTH x (ENTRY_W + SIZE_W) simple dual-port storage.        |
// |             Synchronous write, asynchronous (combinational) read.       |
// |             Contents are never reset.                                   |
// | Ports     : clk      - clock                                            |
// |             i_we     - write enable                                     |
// |             i_waddr  - write address                                    |
// |             i_wdata  - entry data to store                              |
// |             i_wsize  - entry size field to store                        |
// |             i_raddr  - read address                                     |
// |             o_rdata  - entry data at i_raddr                            |
// |             o_rsize  - entry size field at i_raddr                      |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module fifo_wide2narrow_mem
  import fifo_wide2narrow_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
)
(
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [ENTRY_W-1:0]  i_wdata,
  input  logic [SIZE_W-1:0]   i_wsize,
  input  logic [ADDR_W-1:0]   i_raddr,
  output logic [ENTRY_W-1:0]  o_rdata,
  output logic [SIZE_W-1:0]   o_rsize
);

  // Size field is kept in the top bits of each row.
  logic [ENTRY_W+SIZE_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= {i_wsize, i_wdata};
    end
  end

  assign o_rdata = r_mem[i_raddr][ENTRY_W-1:0];
  assign o_rsize = r_mem[i_raddr][ENTRY_W+SIZE_W-1:ENTRY_W];

endmodule
`default_nettype wire

// File: rtl/fifo_wide2narrow_256.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module    : fifo_wide2narrow_256                                        |
// | Purpose   : Synchronous FIFO taking 256-bit entries of 1..16 valid      |
// |             16-bit words and returning one word per read,               |
// |             first-word-fall-through.                                    |
// | Ports     : clk      - clock, rising edge                               |
// |             reset_p  - synchronous active-high reset                    |
// |             data_i   - write entry, word k at [16k+15:16k]              |
// |             size_i   - valid words in data_i (0 = 16)                   |
// |             data_we  - write strobe (ignored while full)                |
// |             data_o   - current head word, valid when empty=0            |
// |             data_rd  - pop head word (ignored while empty)              |
// |             full     - all DEPTH entry slots occupied                   |
// |             empty    - no unread words remain                           |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module fifo_wide2narrow_256
  import fifo_wide2narrow_pkg::*;
#(
  parameter int DEPTH = 16
)
(
  input  logic               clk,
  input  logic               reset_p,
  input  logic [ENTRY_W-1:0] data_i,
  input  logic [SIZE_W-1:0]  size_i,
  input  logic               data_we,
  output logic [WORD_W-1:0]  data_o,
  input  logic               data_rd,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   r_wp;
  logic [PTR_W-1:0]   r_rp;
  logic [CNT_W-1:0]   r_count;
  logic [SIZE_W-1:0]  r_widx;

  logic [ENTRY_W-1:0] w_rd_data;
  logic [SIZE_W-1:0]  w_rd_size;
  logic               w_wr;
  logic               w_pop;
  logic               w_last;
  logic               w_release;

  assign empty = (r_count == '0);
  assign full  = (r_count == c_depth);

  // Admission is decided on the registered full flag only, so a release in
  // the same cycle never lets a write into a full FIFO.
  assign w_wr      = data_we & ~full;
  assign w_pop     = data_rd & ~empty;
  assign w_last    = (r_widx == size_to_last(w_rd_size));
  assign w_release = w_pop & w_last;

  fifo_wide2narrow_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wp),
    .i_wdata (data_i),
    .i_wsize (size_i),
    .i_raddr (r_rp),
    .o_rdata (w_rd_data),
    .o_rsize (w_rd_size)
  );

  // Word select: {widx, 4'b0} is widx*16, the bit offset of the head word.
  assign data_o = w_rd_data[{r_widx, 4'b0000} +: WORD_W];

  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_widx  <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + PTR_W'(1);
      end

      if (w_pop) begin
        if (w_last) begin
          r_rp   <= r_rp + PTR_W'(1);
          r_widx <= '0;
        end else begin
          r_widx <= r_widx + SIZE_W'(1);
        end
      end

      // A write and a release together leave the entry count unchanged.
      if (w_wr && !w_release) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_release && !w_wr) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wide2narrow_256.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module    : tb_fifo_wide2narrow_256                                     |
// | Purpose   : Self-checking bench for fifo_wide2narrow_256. Expected      |
// |             words are queued when entries are written and compared      |
// |             as the DUT pops them.                                       |
// | Revision  : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_fifo_wide2narrow_256;

  localparam int DEPTH  = 16;
  localparam int BUDGET = 128;

  logic         clk = 1'b0;
  logic         reset_p;
  logic [255:0] data_i;
  logic [3:0]   size_i;
  logic         data_we;
  logic [15:0]  data_o;
  logic         data_rd;
  logic         full;
  logic         empty;

  logic [15:0]  exp_q [$];
  int           vectors     = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  fifo_wide2narrow_256 #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .data_i  (data_i),
    .size_i  (size_i),
    .data_we (data_we),
    .data_o  (data_o),
    .data_rd (data_rd),
    .full    (full),
    .empty   (empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand_entry();
    logic [255:0] d;
    for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
    return d;
  endfunction

  // Presents one entry on the write port; the write lands at the next edge.
  // When keep=1 its valid words are queued as expected output.
  task automatic drive_write(input logic [255:0] d, input logic [3:0] sz, input bit keep);
    int n;
    data_i  = d;
    size_i  = sz;
    data_we = 1'b1;
    n = (sz == 4'd0) ? 16 : int'(sz);
    if (keep) for (int k = 0; k < n; k++) exp_q.push_back(d[16*k +: 16]);
  endtask

  task automatic test_reset();
    reset_p = 1'b1; data_we = 1'b0; data_rd = 1'b0; data_i = '0; size_i = '0;
    tick(); tick();
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
    vectors++;
    if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
    reset_p = 1'b0;
    tick();
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_flags: empty=%b full=%b want 1 0", empty, full);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 8; i++) begin
      data_rd = i[0];
      tick();
      vectors++;
      if (empty !== 1'b1 || full !== 1'b0) begin
        miscompares++; $display("FAIL idle_flags[%0d]: empty=%b full=%b want 1 0", i, empty, full);
      end
    end
    data_rd = 1'b0;
  endtask

  task automatic test_full_entry();
    logic [255:0] d;
    logic [15:0]  e;
    int           n;
    for (int k = 0; k < 16; k++) d[16*k +: 16] = 16'(k);
    drive_write(d, 4'd0, 1'b1);
    tick();
    data_we = 1'b0;
    data_rd = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < BUDGET) begin
      vectors++;
      if (empty !== 1'b0) begin
        miscompares++; $display("FAIL full_entry_empty: got %b want 0", empty);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin miscompares++; $display("FAIL full_entry_data: got %h want %h", data_o, e); end
      end
      tick(); n++;
    end
    if (exp_q.size() != 0) begin vectors++; miscompares++; $display("FAIL full_entry_timeout: %0d words left want 0", exp_q.size()); end
    data_rd = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL full_entry_end_empty: got %b want 1", empty); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    logic [15:0]  e;
    int           n;
    d = rand_entry();
    for (int k = 0; k < 3; k++) d[16*k +: 16] = 16'h00A0 + 16'(k);
    drive_write(d, 4'd3, 1'b1);
    tick();
    d = rand_entry();
    d[15:0] = 16'h00B0;
    drive_write(d, 4'd1, 1'b1);
    data_rd = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < BUDGET) begin
      vectors++;
      if (empty !== 1'b0) begin
        miscompares++; $display("FAIL b2b_bubble: empty=%b want 0", empty);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin miscompares++; $display("FAIL b2b_data: got %h want %h", data_o, e); end
      end
      tick(); n++;
      data_we = 1'b0;
    end
    if (exp_q.size() != 0) begin vectors++; miscompares++; $display("FAIL b2b_timeout: %0d words left want 0", exp_q.size()); end
    data_rd = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL b2b_end_empty: got %b want 1", empty); end
    exp_q.delete();
  endtask

  task automatic test_full();
    logic [255:0] d;
    logic [3:0]   sz;
    logic [15:0]  e;
    int           n;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        vectors++;
        if (full !== 1'b0) begin miscompares++; $display("FAIL full_early: got %b want 0", full); end
      end
      d = rand_entry();
      for (int k = 0; k < 16; k++) d[16*k +: 16] = {8'(i), 8'(k)};
      sz = (i == 7) ? 4'd0 : 4'(i % 4 + 1);
      drive_write(d, sz, 1'b1);
      tick();
    end
    data_we = 1'b0;
    vectors++;
    if (full !== 1'b1 || empty !== 1'b0) begin
      miscompares++; $display("FAIL full_set: full=%b empty=%b want 1 0", full, empty);
    end
    d = {16{16'hDEAD}};
    drive_write(d, 4'd0, 1'b0);
    tick();
    data_we = 1'b0;
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("FAIL full_after_drop: got %b want 1", full); end
    data_rd = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < BUDGET) begin
      vectors++;
      if (empty !== 1'b0) begin
        miscompares++; $display("FAIL full_drain_empty: got %b want 0", empty);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin miscompares++; $display("FAIL full_drain_data: got %h want %h", data_o, e); end
      end
      tick(); n++;
    end
    if (exp_q.size() != 0) begin vectors++; miscompares++; $display("FAIL full_drain_timeout: %0d words left want 0", exp_q.size()); end
    data_rd = 1'b0;
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      miscompares++; $display("FAIL full_end_flags: empty=%b full=%b want 1 0", empty, full);
    end
    exp_q.delete();
  endtask

  task automatic test_stream();
    logic [255:0] d;
    logic [15:0]  e;
    for (int i = 0; i < 2; i++) begin
      d = rand_entry();
      d[15:0] = 16'h0F00 + 16'(i);
      drive_write(d, 4'd1, 1'b1);
      tick();
    end
    // Two entries stay resident while one enters and one leaves each cycle.
    for (int i = 0; i < 42; i++) begin
      data_rd = 1'b1;
      if (i < 40) begin
        d = rand_entry();
        d[15:0] = 16'h1000 + 16'(i);
        drive_write(d, 4'd1, 1'b1);
        vectors++;
        if (full !== 1'b0) begin miscompares++; $display("FAIL stream_full[%0d]: got %b want 0", i, full); end
      end else begin
        data_we = 1'b0;
      end
      if (exp_q.size() > 0) begin
        vectors++;
        if (empty !== 1'b0) begin
          miscompares++; $display("FAIL stream_empty[%0d]: got %b want 0", i, empty);
        end else begin
          e = exp_q.pop_front();
          if (data_o !== e) begin miscompares++; $display("FAIL stream_data[%0d]: got %h want %h", i, data_o, e); end
        end
      end
      tick();
    end
    data_rd = 1'b0;
    data_we = 1'b0;
    vectors++;
    if (empty !== 1'b1 || exp_q.size() != 0) begin
      miscompares++; $display("FAIL stream_end: empty=%b left=%0d want 1 0", empty, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic [255:0] d;
    logic [15:0]  e;
    int           n;
    for (int i = 0; i < 3; i++) begin
      drive_write(rand_entry(), 4'd0, 1'b1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      data_rd = 1'b1;
      drive_write(rand_entry(), 4'd0, 1'b1);
      vectors++;
      if (empty !== 1'b0) begin
        miscompares++; $display("FAIL mid_empty[%0d]: got %b want 0", i, empty);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin miscompares++; $display("FAIL mid_data[%0d]: got %h want %h", i, data_o, e); end
      end
      tick();
    end
    reset_p = 1'b1;
    data_we = 1'b1;
    data_rd = 1'b1;
    tick();
    exp_q.delete();
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_flags: empty=%b full=%b want 1 0", empty, full);
    end
    reset_p = 1'b0;
    data_we = 1'b0;
    data_rd = 1'b0;
    d = rand_entry();
    d[15:0]  = 16'h5A00;
    d[31:16] = 16'h5A01;
    drive_write(d, 4'd2, 1'b1);
    tick();
    data_we = 1'b0;
    data_rd = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < BUDGET) begin
      vectors++;
      if (empty !== 1'b0) begin
        miscompares++; $display("FAIL after_reset_empty: got %b want 0", empty);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin miscompares++; $display("FAIL after_reset_data: got %h want %h", data_o, e); end
      end
      tick(); n++;
    end
    if (exp_q.size() != 0) begin vectors++; miscompares++; $display("FAIL after_reset_timeout: %0d words left want 0", exp_q.size()); end
    data_rd = 1'b0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL after_reset_end_empty: got %b want 1", empty); end
    exp_q.delete();
  endtask

  initial begin
    reset_p = 1'b1;
    data_we = 1'b0;
    data_rd = 1'b0;
    data_i  = '0;
    size_i  = '0;
    test_reset();
    test_idle();
    test_full_entry();
    test_back_to_back();
    test_full();
    test_stream();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/fifo_wide2narrow_256.md
Name: fifo_wide2narrow_256

Overview:
- Synchronous FIFO that accepts 256-bit entries, each holding 1..16 valid 16-bit words, and returns them one 16-bit word per read.
- Sits behind a wide read port in a credit-return datapath: wide data is written in, and the narrow AXI-stream-like output drains it.
- The producer is credit-limited, so overflow is not expected; the behaviour on overflow is still defined below.

Parameters:
- DEPTH, 16, number of 256-bit entries stored. Must be a power of 2 and at least 2. Word capacity is DEPTH*16.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_p  in  1  synchronous, active-high reset.
- data_i  in  256  write entry; word k is data_i[16k+15:16k].
- size_i  in  4  number of valid words in data_i, taken from word 0 upward. 0 means 16 words; 1..15 mean that many words.
- data_we  in  1  write strobe; one entry is written per cycle.
- data_o  out  16  current head word (first-word-fall-through).
- data_rd  in  1  pops the head word when empty=0.
- full  out  1  all DEPTH entry slots are occupied.
- empty  out  1  no unread words remain.

Behaviour:
- Storage:
  - DEPTH x 256 data array plus DEPTH x 4 size array.
  - Write pointer and read pointer, each log2(DEPTH) bits.
  - Entry count, log2(DEPTH)+1 bits.
  - 4-bit word index within the head entry.
- Reset (reset_p=1 at a clock edge):
  - Pointers, count and word index go to 0.
  - empty=1, full=0.
  - Array contents are not cleared.
  - Reset takes priority over data_we and data_rd in the same cycle, and discards everything in flight.
- Write: data_we=1 and full=0 stores data_i and size_i at the write pointer, then wp++ (wraps modulo DEPTH) and count++.
  - data_we=1 while full=1 is ignored and the entry is dropped; it must not corrupt state.
- Read output:
  - data_o = mem[rp] word[widx], driven combinationally from the registered state.
  - data_o is valid whenever empty=0.
  - When empty=1, data_o is don't-care and must not be checked.
- Pop: data_rd=1 and empty=0 consumes the head word.
  - If widx == last index, the entry is released: rp++, count--, widx=0. Last index is size-1, or 15 when size=0.
  - Otherwise widx++.
  - data_rd while empty is ignored.
- Latency: a write at edge N gives empty=0 and a valid data_o after edge N. There is no read-through in the same cycle.
- Flags: empty = (count==0); full = (count==DEPTH). Both are decoded from registered state.
- Simultaneous write and entry-release in one cycle: count is unchanged, both pointers advance.
  - Writing while full is allowed only if full=0 at that edge; a same-cycle release does not admit a write when full=1.
- Word order: entries are read in write order; within an entry words go from index 0 upward. Unused upper words are never output.
- Throughput:
  - Sustained 1 word/cycle out.
  - Back-to-back entries with no bubble, including single-word entries.

Decomposition:
- Package fifo_wide2narrow_pkg holds:
  - WORD_W=16, WORDS_PER_ENTRY=16, ENTRY_W=256, SIZE_W=4.
  - A function size_to_last(size) returning 15 when size=0, otherwise size-1.
- One natural sub-module, fifo_wide2narrow_mem: a simple dual-port DEPTH x (256+4) array with a synchronous write and an asynchronous read at rp.
- Pointer, count and word-index control stays in the top module.

Test Plan:
- Reset, then idle: empty=1 and full=0 every cycle; data_rd pulses change nothing.
- Write one entry with words 0x0000..0x000F and size_i=0, then hold data_rd=1: data_o is 0x0000 through 0x000F on 16 consecutive cycles, then empty=1.
- Write an entry with size_i=3 (words 0xA0,0xA1,0xA2,...) followed by an entry with size_i=1 (word 0xB0), then read continuously: the output is exactly 0xA0,0xA1,0xA2,0xB0, with no bubble between entries.
- Write 16 entries without reading: full=1 after the 16th write. A 17th write is dropped, and reading afterwards returns only the original 16 entries in order.
- Steady stream of single-word entries, writing and reading every cycle: count stays constant, full/empty are stable, and data order is preserved across pointer wrap.
- Assert reset_p mid-stream while data_we=1 and data_rd=1: on the next cycle empty=1; new writes afterwards are read back correctly from index 0.
